ramp_sequencer: RTL and testbench

Conversion controller for the single-slope ramp ADC. It is the driving end of the double-rate sampler interface: it generates the shared `counter` ramp and holds the sampler's phase alignment. After each ramp it collects the captured code and delivers it to the readout logic over a valid/ready handshake. One instance sits beside each sampler, between the comparator front end and the trace buffer.

---
 rtl/ramp_pkg.sv | 19 +
 rtl/pulse_detect.sv | 35 +++
 rtl/ramp_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_ramp_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ramp_pkg.sv
// ramp_pkg: definitions shared by the ramp sequencer, the sampler model and
// the readout logic.
//   ramp_state_t : conversion controller state
//   PH_SET/PH_RST: ramp phase encoding. A set cycle presents a stable code to
//                  the sampler. A reset cycle is the one where the code advances.
package ramp_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    RAMP   = 3'd2,
    HOLD   = 3'd3,
    OUTPUT = 3'd4
  } ramp_state_t;

  localparam logic PH_SET = 1'b0;
  localparam logic PH_RST = 1'b1;

endpackage

// File: rtl/pulse_detect.sv
// pulse_detect: rising-edge detector with a qualifying enable.
//   clk   : clock
//   rst   : synchronous active-high reset; clears the remembered level
//   en    : sample enable; the remembered level only updates when high
//   d     : level to watch
//   pulse : registered, high for one cycle after an enabled sample saw d=1
//           while the previous enabled sample saw d=0
module pulse_detect (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic pulse
);

  logic prev_r;
  logic pulse_r;

  // Remember the last enabled sample and flag an enabled 0->1 transition
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_r  <= 1'b0;
      pulse_r <= 1'b0;
    end else if (en) begin
      prev_r  <= d;
      pulse_r <= d & ~prev_r;
    end else begin
      prev_r  <= prev_r;
      pulse_r <= 1'b0;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/ramp_sequencer.sv
// ramp_sequencer: conversion controller for the single-slope ramp ADC.
// It generates the shared ramp code, keeps the double-rate sampler phase aligned,
// and hands each captured code to readout over valid/ready.
//   clk, rst           : clock, synchronous active-high reset
//   start              : request one conversion
//   comp               : raw comparator output (same net as the sampler's)
//   count_true         : code captured by the sampler
//   counter            : ramp code to the DAC and the sampler
//   smp_rst, comp_rst  : sampler reset / comparator auto-zero, high in SETTLE
//   busy               : high in every state except IDLE
//   sample_valid/ready : result handshake
//   sample_data        : result code, sample_ovf: no comparator edge was seen
module ramp_sequencer #(
  parameter int WIDTH         = 8,
  parameter int RAMP_MAX      = 2**WIDTH-1,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             comp,
  input  logic [WIDTH-1:0] count_true,
  output logic [WIDTH-1:0] counter,
  output logic             smp_rst,
  output logic             comp_rst,
  output logic             busy,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic [WIDTH-1:0] sample_data,
  output logic             sample_ovf
);

  import ramp_pkg::*;

  localparam int SCW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SCW-1:0]   SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);
  // HOLD reuses the settle counter: load 1, leave HOLD when it reaches 0
  localparam logic [SCW-1:0]   HOLD_LOAD   = SCW'(1);
  localparam logic [SCW-1:0]   CNT_ZERO    = {SCW{1'b0}};
  localparam logic [SCW-1:0]   CNT_ONE     = SCW'(1);
  localparam logic [WIDTH-1:0] CODE_MAX    = WIDTH'(RAMP_MAX);
  localparam logic [WIDTH-1:0] CODE_ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CODE_ONE    = WIDTH'(1);

  ramp_state_t      state_r, state_nxt_s;
  logic [SCW-1:0]   settle_cnt_r, settle_cnt_nxt_s;
  logic [WIDTH-1:0] counter_r, counter_nxt_s;
  logic             phase_r, phase_nxt_s;
  logic             hit_seen_r, hit_seen_nxt_s;
  logic [WIDTH-1:0] data_r, data_nxt_s;
  logic             ovf_r, ovf_nxt_s;
  logic             busy_r, smp_rst_r, comp_rst_r, valid_r;
  logic             det_rst_s, det_en_s, hit_pulse_s;

  // The detector is reset with the sampler so both see the same edge history
  assign det_rst_s = rst | smp_rst_r;
  assign det_en_s  = (state_r == RAMP) && (phase_r == PH_SET);

  pulse_detect u_pulse_detect (
    .clk   (clk),
    .rst   (det_rst_s),
    .en    (det_en_s),
    .d     (comp),
    .pulse (hit_pulse_s)
  );

  // Next-state logic of the conversion FSM
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = SETTLE;
        else       state_nxt_s = IDLE;
      end
      SETTLE: begin
        if (settle_cnt_r == CNT_ZERO) state_nxt_s = RAMP;
        else                          state_nxt_s = SETTLE;
      end
      RAMP: begin
        if ((phase_r == PH_RST) && (counter_r == CODE_MAX)) state_nxt_s = HOLD;
        else                                                 state_nxt_s = RAMP;
      end
      HOLD: begin
        if (settle_cnt_r == CNT_ZERO) state_nxt_s = OUTPUT;
        else                          state_nxt_s = HOLD;
      end
      OUTPUT: begin
        if (sample_ready) state_nxt_s = start ? SETTLE : IDLE;
        else              state_nxt_s = OUTPUT;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath next values: settle/hold counter, ramp code, phase, result latch
  always_comb begin
    settle_cnt_nxt_s = settle_cnt_r;
    counter_nxt_s    = counter_r;
    phase_nxt_s      = PH_SET;
    data_nxt_s       = data_r;
    ovf_nxt_s        = ovf_r;
    case (state_r)
      IDLE: begin
        counter_nxt_s = CODE_ZERO;
        if (state_nxt_s == SETTLE) settle_cnt_nxt_s = SETTLE_LOAD;
        else                       settle_cnt_nxt_s = settle_cnt_r;
      end
      SETTLE: begin
        counter_nxt_s = CODE_ZERO;
        if (settle_cnt_r != CNT_ZERO) settle_cnt_nxt_s = settle_cnt_r - CNT_ONE;
        else                          settle_cnt_nxt_s = settle_cnt_r;
      end
      RAMP: begin
        phase_nxt_s = ~phase_r;
        // Advance only at the end of a reset cycle; the final code is held
        if ((phase_r == PH_RST) && (counter_r != CODE_MAX)) counter_nxt_s = counter_r + CODE_ONE;
        else                                                 counter_nxt_s = counter_r;
        if (state_nxt_s == HOLD) settle_cnt_nxt_s = HOLD_LOAD;
        else                     settle_cnt_nxt_s = settle_cnt_r;
      end
      HOLD: begin
        if (settle_cnt_r != CNT_ZERO) settle_cnt_nxt_s = settle_cnt_r - CNT_ONE;
        else                          settle_cnt_nxt_s = settle_cnt_r;
        if (state_nxt_s == OUTPUT) begin
          data_nxt_s = hit_seen_r ? count_true : CODE_MAX;
          ovf_nxt_s  = ~hit_seen_r;
        end else begin
          data_nxt_s = data_r;
          ovf_nxt_s  = ovf_r;
        end
      end
      OUTPUT: begin
        if (sample_ready) counter_nxt_s = CODE_ZERO;
        else              counter_nxt_s = counter_r;
        if (state_nxt_s == SETTLE) settle_cnt_nxt_s = SETTLE_LOAD;
        else                       settle_cnt_nxt_s = settle_cnt_r;
      end
      default: begin
        counter_nxt_s    = CODE_ZERO;
        settle_cnt_nxt_s = CNT_ZERO;
      end
    endcase
  end

  // Only the first edge of a ramp counts; SETTLE clears it for the next ramp
  always_comb begin
    hit_seen_nxt_s = hit_seen_r;
    if (state_r == SETTLE) hit_seen_nxt_s = 1'b0;
    else if (hit_pulse_s)  hit_seen_nxt_s = 1'b1;
    else                   hit_seen_nxt_s = hit_seen_r;
  end

  // State and registered outputs; outputs are decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      settle_cnt_r <= CNT_ZERO;
      counter_r    <= CODE_ZERO;
      phase_r      <= PH_SET;
      hit_seen_r   <= 1'b0;
      data_r       <= CODE_ZERO;
      ovf_r        <= 1'b0;
      busy_r       <= 1'b0;
      smp_rst_r    <= 1'b0;
      comp_rst_r   <= 1'b0;
      valid_r      <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      settle_cnt_r <= settle_cnt_nxt_s;
      counter_r    <= counter_nxt_s;
      phase_r      <= phase_nxt_s;
      hit_seen_r   <= hit_seen_nxt_s;
      data_r       <= data_nxt_s;
      ovf_r        <= ovf_nxt_s;
      busy_r       <= (state_nxt_s != IDLE);
      smp_rst_r    <= (state_nxt_s == SETTLE);
      comp_rst_r   <= (state_nxt_s == SETTLE);
      valid_r      <= (state_nxt_s == OUTPUT);
    end
  end

  assign counter      = counter_r;
  assign smp_rst      = smp_rst_r;
  assign comp_rst     = comp_rst_r;
  assign busy         = busy_r;
  assign sample_valid = valid_r;
  assign sample_data  = data_r;
  assign sample_ovf   = ovf_r;

endmodule

// File: tb/tb_ramp_sequencer.sv
// tb_ramp_sequencer: ramp_sequencer with WIDTH=4, RAMP_MAX=15, SETTLE_CYCLES=2,
// paired with a small double-rate sampler model. Expected outputs per cycle are
// derived from the conversion timeline (cycle index since start was accepted).
module tb_ramp_sequencer;

  localparam int WIDTH = 4;
  localparam int S     = 2;
  localparam int R     = 15;
  localparam int L     = 3 + S + 2*(R+1);

  logic             clk = 1'b0;
  logic             rst, start, comp, sample_ready;
  logic [WIDTH-1:0] count_true, counter, sample_data;
  logic             smp_rst, comp_rst, busy, sample_valid, sample_ovf;

  int n_vec = 0;
  int n_err = 0;

  logic        chk_en, chk_data;
  logic [3:0]  exp_counter, exp_data;
  logic        exp_smp, exp_busy, exp_valid, exp_ovf;
  logic [3:0]  got_data;
  logic        got_ovf;

  always #5 clk = ~clk;

  ramp_sequencer #(.WIDTH(WIDTH), .RAMP_MAX(R), .SETTLE_CYCLES(S)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .comp         (comp),
    .count_true   (count_true),
    .counter      (counter),
    .smp_rst      (smp_rst),
    .comp_rst     (comp_rst),
    .busy         (busy),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_data  (sample_data),
    .sample_ovf   (sample_ovf)
  );

  // Sampler model: captures the ramp code at the first set-cycle comparator edge
  logic       s_ph, s_prev, s_hit;
  logic [3:0] s_cap;
  always_ff @(posedge clk) begin
    if (rst || smp_rst) begin
      s_ph <= 1'b0; s_prev <= 1'b0; s_hit <= 1'b0; s_cap <= 4'd0;
    end else begin
      s_ph <= ~s_ph;
      if (!s_ph) begin
        s_prev <= comp;
        if (comp && !s_prev && !s_hit) begin
          s_hit <= 1'b1;
          s_cap <= counter;
        end
      end
    end
  end
  assign count_true = s_cap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Result of a ramp given comparator levels on set cycles 0..15
  function automatic void model(input logic [15:0] setp, output logic [3:0] code, output logic ovf);
    code = 4'd15;
    ovf  = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (setp[k] && (k == 0 || !setp[k-1])) begin
        code = 4'(k);
        ovf  = 1'b0;
        break;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("counter", {28'd0, counter}, {28'd0, exp_counter});
      check("smp_rst", {31'd0, smp_rst}, {31'd0, exp_smp});
      check("comp_rst", {31'd0, comp_rst}, {31'd0, exp_smp});
      check("busy", {31'd0, busy}, {31'd0, exp_busy});
      check("valid", {31'd0, sample_valid}, {31'd0, exp_valid});
      if (chk_data) begin
        check("data", {28'd0, sample_data}, {28'd0, exp_data});
        check("ovf", {31'd0, sample_ovf}, {31'd0, exp_ovf});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    exp_counter = 4'd0; exp_smp = 1'b0; exp_busy = 1'b0; exp_valid = 1'b0; chk_data = 1'b0;
  endtask

  task automatic set_reset_exp();
    set_idle_exp();
    chk_data = 1'b1; exp_data = 4'd0; exp_ovf = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    comp  = 1'b0;
    tick();
    start = 1'b0;
  endtask

  // Drives one conversion from cycle 1 (the cycle after start was accepted)
  task automatic convert(input logic [15:0] setp, input int stall, input bit chain, input int abort_at);
    logic [3:0] code;
    logic       ovf;
    int         off, k;
    model(setp, code, ovf);
    for (int c = 1; c <= L + stall; c++) begin
      start        = 1'($urandom_range(0, 1));
      sample_ready = 1'($urandom_range(0, 1));
      comp         = 1'b0;
      exp_busy  = 1'b1;
      exp_smp   = (c <= S);
      exp_valid = (c >= L);
      chk_data  = (c >= L);
      exp_data  = code;
      exp_ovf   = ovf;
      if (c <= S) begin
        exp_counter = 4'd0;
        comp = 1'($urandom_range(0, 1));
      end else if (c <= S + 2*(R+1)) begin
        off = c - S - 1;
        k   = off / 2;
        exp_counter = 4'(k);
        comp = ((off % 2) == 0) ? setp[k] : 1'($urandom_range(0, 1));
      end else begin
        exp_counter = 4'(R);
      end
      if (c >= L) begin
        if (c == L) begin
          got_data = sample_data;
          got_ovf  = sample_ovf;
        end
        sample_ready = (c == L + stall);
        start = (c == L + stall) ? chain : 1'($urandom_range(0, 1));
      end
      if (c == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        comp  = 1'b0;
        set_reset_exp();
        return;
      end
      tick();
    end
    start = 1'b0;
    comp  = 1'b0;
    if (!chain) set_idle_exp();
  endtask

  initial begin
    logic [15:0] setp;
    logic [15:0] ones;
    bit          chain;
    bit          chained;
    int          mode;
    rst = 1'b1; start = 1'b0; comp = 1'b0; sample_ready = 1'b0; chk_en = 1'b0;
    set_reset_exp();
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();

    // comparator rises at code 9
    go();
    convert(16'hFE00, 0, 1'b0, 0);
    check("t1_data", {28'd0, got_data}, 32'd9);
    check("t1_ovf", {31'd0, got_ovf}, 32'd0);
    tick();

    // no edge at all
    go();
    convert(16'h0000, 0, 1'b0, 0);
    check("t2_data", {28'd0, got_data}, 32'd15);
    check("t2_ovf", {31'd0, got_ovf}, 32'd1);

    // high from the start, later edge at 12 ignored
    go();
    convert(16'hF3FF, 0, 1'b0, 0);
    check("t3_data", {28'd0, got_data}, 32'd0);
    check("t3_ovf", {31'd0, got_ovf}, 32'd0);

    // stalled consumer, then back-to-back conversion
    go();
    convert(16'h0FF0, 10, 1'b1, 0);
    check("t4a_data", {28'd0, got_data}, 32'd4);
    convert(16'h0100, 0, 1'b0, 0);
    check("t4b_data", {28'd0, got_data}, 32'd8);

    // reset at counter 7 mid-ramp, then a clean conversion
    go();
    convert(16'hFFC0, 0, 1'b0, S + 1 + 14);
    tick();
    go();
    convert(16'hFFC0, 0, 1'b0, 0);
    check("t5_data", {28'd0, got_data}, 32'd6);
    check("t5_ovf", {31'd0, got_ovf}, 32'd0);

    // random comparator patterns, random stalls, random chaining
    chained = 1'b0;
    ones = 16'hFFFF;
    for (int n = 0; n < 50; n++) begin
      mode = $urandom_range(0, 3);
      if (mode == 0)      setp = 16'h0000;
      else if (mode == 1) setp = ones << $urandom_range(0, 15);
      else                setp = 16'($urandom);
      chain = 1'($urandom_range(0, 1));
      if (!chained) begin
        for (int g = 0; g < $urandom_range(0, 2); g++) tick();
        go();
      end
      convert(setp, $urandom_range(0, 3), chain, 0);
      chained = chain;
    end
    if (chained) convert(16'h0000, 0, 1'b0, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
